uart_tx_arbiter: RTL

//  Shares one UART transmitter among N_REQ byte-stream requesters. Round-robin grant

---
 rtl/uart_arb_pkg.sv | 29 ++
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the uart tx arbiter
// Purpose: FSM state enum, byte width, requester-count limits and small
//          index helpers used by uart_tx_arbiter and rr_pick.
// Ports:   none (package).
package uart_arb_pkg;

  localparam int BYTE_W    = 8;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_HOLD    = 3'd4
  } arb_state_t;

  // (a + b) mod n for small non-negative operands.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

  // Next round-robin position after idx, wrapping n-1 -> 0.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart-tx signal bundle for the arbiter
// Purpose: groups the requester byte streams and the uart TX handshake.
// Ports (signals):
//   req_valid/req_data/req_last  requester -> arbiter, one lane per requester
//   req_ready                    arbiter -> requester, at most one bit set
//   uart_tx_start/uart_tx_byte   arbiter -> uart TX
//   uart_tx_busy                 uart TX -> arbiter
// Modports: master = requesters + uart side, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    uart_tx_start;
  logic [BYTE_W-1:0]       uart_tx_byte;
  logic                    uart_tx_busy;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_start, uart_tx_byte
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_start, uart_tx_byte
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: selects the first set request at or after ptr, wrapping past N-1.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  highest-priority index
//   grant  out N   one-hot winner (zero when no request)
//   idx    out PW  winner index (zero when no request)
//   any    out 1   at least one request set
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Walk candidates in priority order; the first hit wins and masks the rest.
    for (int off = 0; off < N; off++) begin
      if (!any && req[PW'(wrap_add(int'(ptr), off, N))]) begin
        any = 1'b1;
        idx = PW'(wrap_add(int'(ptr), off, N));
        grant[PW'(wrap_add(int'(ptr), off, N))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one uart transmitter
// Purpose: grants the uart TX to one requester at a time; the owner keeps the
//          lock until its req_last byte has been sent or a busy timeout occurs.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   bus           slave modport of uart_tx_arbiter_if (requesters + uart TX)
//   grant_active  out  lock held by grant_id
//   grant_id      out  current owner, meaningful while grant_active
//   err_timeout   out  one-cycle pulse when uart_tx_busy never rose after a start
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.slave         bus,
  output logic                     grant_active,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_timeout
);

  localparam int            IDW     = $clog2(N_REQ);
  localparam int            CW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ out of supported range");
  end

  arb_state_t        state, state_nxt;
  logic [IDW-1:0]    owner;
  logic [IDW-1:0]    ptr;
  logic [BYTE_W-1:0] byte_q;
  logic              last_q;
  logic              lock_q;
  logic [CW-1:0]     cnt;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;

  logic              accept;
  logic [IDW-1:0]    accept_id;
  logic              release_lock;

  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = bus.req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N  (N_REQ),
    .PW (IDW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt         = state;
    bus.req_ready     = '0;
    bus.uart_tx_start = 1'b0;
    err_timeout       = 1'b0;
    accept            = 1'b0;
    accept_id         = owner;
    release_lock      = 1'b0;

    case (state)
      ST_IDLE: begin
        // A busy transmitter (e.g. finishing someone else's frame) blocks new grants.
        if (!bus.uart_tx_busy && pick_any) begin
          bus.req_ready = pick_grant;
          accept        = 1'b1;
          accept_id     = pick_idx;
          state_nxt     = ST_START;
        end
      end
      ST_START: begin
        bus.uart_tx_start = 1'b1;
        state_nxt         = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.uart_tx_busy) begin
          state_nxt = ST_WAIT_LO;
        end else if (cnt == CNT_MAX) begin
          // Transmitter never acknowledged: drop the byte and free the lock.
          err_timeout  = 1'b1;
          release_lock = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
          if (last_q) begin
            release_lock = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Only the lock owner is served; it may leave gaps between its bytes.
        if (bus.req_valid[owner]) begin
          bus.req_ready[owner] = 1'b1;
          accept               = 1'b1;
          state_nxt            = ST_START;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      ptr    <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      lock_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner  <= accept_id;
        byte_q <= req_bytes[accept_id];
        last_q <= bus.req_last[accept_id];
        lock_q <= 1'b1;
      end
      if (release_lock) begin
        lock_q <= 1'b0;
        ptr    <= IDW'(next_index(int'(owner), N_REQ));
      end
      // Saturating wait counter, restarted on every tx_start.
      if (state == ST_START) begin
        cnt <= '0;
      end else if (state == ST_WAIT_HI && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign grant_active     = lock_q;
  assign grant_id         = owner;
  assign bus.uart_tx_byte = byte_q;

endmodule
